// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-read/single-write word memory among
// NUM_REQ requesters, with a 2-stage tag pipe that routes read data back.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wen,
  input  logic [NUM_REQ*15-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [14:0]           mem_raddr,
  input  logic [15:0]           mem_rdata,
  output logic                  mem_wen,
  output logic [14:0]           mem_waddr,
  output logic [15:0]           mem_wdata,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  output logic                  busy
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           g_wen;
  logic [14:0]    g_addr;
  logic [15:0]    g_wdata;
  logic           rd_gnt;
  logic           s1_v, s2_v;
  logic [IDW-1:0] s1_id, s2_id;
  logic [14:0]    last_raddr;

  // Walk NUM_REQ slots starting at rr_ptr; the pointer never exceeds
  // NUM_REQ-1, so a single subtraction is enough to wrap.
  always_comb begin
    logic [IDW:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ))
        idx = idx - (IDW+1)'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (rst_n && !gnt_any && idx == (IDW+1)'(j) && req_valid[j]) begin
          gnt_any = 1'b1;
          gnt_idx = IDW'(j);
        end
      end
    end
  end

  always_comb begin
    g_wen     = 1'b0;
    g_addr    = '0;
    g_wdata   = '0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_any && gnt_idx == IDW'(j)) begin
        req_ready[j] = 1'b1;
        g_wen        = req_wen[j];
        g_addr       = req_addr[15*j +: 15];
        g_wdata      = req_wdata[16*j +: 16];
      end
    end
  end

  assign rd_gnt    = gnt_any && !g_wen;
  assign mem_wen   = gnt_any && g_wen;
  assign mem_waddr = mem_wen ? g_addr  : 15'd0;
  assign mem_wdata = mem_wen ? g_wdata : 16'd0;
  assign mem_raddr = rd_gnt  ? g_addr  : last_raddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s1_id      <= '0;
      s2_id      <= '0;
      last_raddr <= '0;
    end else begin
      if (gnt_any)
        rr_ptr <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
      s1_v  <= rd_gnt;
      s1_id <= gnt_idx;
      s2_v  <= s1_v;
      s2_id <= s1_id;
      if (rd_gnt)
        last_raddr <= g_addr;
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++)
      resp_valid[j] = s2_v && s2_id == IDW'(j);
  end

  assign resp_data = mem_rdata;
  assign busy      = s1_v | s2_v;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-read/single-write word memory (15-bit word address, 16-bit data, 2-cycle registered read) between NUM_REQ requesters, e.g. per-core fetch and load/store units.
- Grants at most one access per cycle, chosen round-robin among requesters.
- Drives the memory read-address and write ports, tracks in-flight reads through a 2-stage tag pipeline, and steers each returning read word back to the requester that issued it.
- Sits directly between the core request buses and the memory instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 3, width of grant index; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_wen  in  NUM_REQ  per-requester write flag; 1=write, 0=read.
- req_addr  in  NUM_REQ*15  flattened word addresses; slice i = [15*i+14:15*i].
- req_wdata  in  NUM_REQ*16  flattened write data; slice i = [16*i+15:16*i].
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- mem_raddr  out  15  to memory read address input.
- mem_rdata  in  16  from memory read data output.
- mem_wen  out  1  to memory write enable.
- mem_waddr  out  15  to memory write address.
- mem_wdata  out  16  to memory write data.
- resp_valid  out  NUM_REQ  one-hot read-data-return strobe.
- resp_data  out  16  shared read data; meaningful only where resp_valid is set.
- busy  out  1  at least one read in flight.

Behaviour:
- Handshake:
  - A request transfers in a cycle where req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid, wen, addr and wdata stable until granted.
  - req_ready never depends on resp_valid.
- Arbitration:
  - Register rr_ptr (IDW bits) names the highest-priority requester.
  - Search order is rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid requester is granted.
  - After any grant to requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - req_ready has at most one bit set, and only on a bit where req_valid is set.
- Granted write, combinational in the grant cycle:
  - mem_wen=1, mem_waddr=req_addr[g], mem_wdata=req_wdata[g].
  - The memory commits at the same posedge.
- Granted read, combinational in the grant cycle:
  - mem_raddr=req_addr[g].
  - Push tag {1, g} into pipe stage s1 at the posedge.
- Idle outputs:
  - With no write grant, mem_wen=0 and mem_waddr/mem_wdata=0.
  - With no read grant, mem_raddr holds the last granted read address in register last_raddr (reset 0).
- Read latency: exactly 2 cycles.
  - Read granted in cycle k gives resp_valid[g]=1 in cycle k+2.
  - In that cycle, resp_data=mem_rdata.
  - Tag pipe: s1 <= new tag; s2 <= s1; resp_valid = onehot(s2) when s2.valid.
  - resp_data = mem_rdata (pass-through, no extra register).
- Throughput: one access per cycle, back-to-back; up to 2 reads in flight.
- busy = s1.valid | s2.valid.
- Ordering:
  - A write granted in cycle k is visible to any read granted in cycle k+1 or later.
  - A read and a write never issue in the same cycle (single grant).
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0; pointer values >= NUM_REQ are unreachable.
- Reset (rst_n=0 at posedge), also when asserted mid-operation:
  - rr_ptr=0, s1/s2 valid=0, last_raddr=0.
  - In-flight reads are discarded: no resp_valid after reset.
  - While rst_n=0, req_ready=0 and mem_wen=0, regardless of req_valid.
  - resp_valid=0 from the first cycle after reset.

Test Plan:
- Reset then single read: r0 reads addr 0x0010 holding 0xBEEF in cycle 5 -> req_ready=0001 in cycle 5; resp_valid=0001 with resp_data=0xBEEF in cycle 7; busy=1 in cycles 6-7.
- Write then read: r1 writes 0x1234 to addr 0x7FFF in cycle 3, then reads 0x7FFF in cycle 4 -> mem_wen=1 in cycle 3; resp_valid=0010, resp_data=0x1234 in cycle 6.
- Round-robin fairness: all 4 requesters issue continuous reads from rr_ptr=0 -> grants 0,1,2,3,0,1... one per cycle; responses follow in the same order 2 cycles later; no requester waits more than 3 cycles.
- Pointer skip: only r2 and r0 valid with rr_ptr=1 -> r2 granted first, rr_ptr becomes 3, then r0 granted, rr_ptr becomes 1.
- Reset mid-flight: reads granted in cycles 10 and 11, rst_n=0 in cycle 11 -> no resp_valid in cycles 12-13; busy=0 after reset.
- NUM_REQ=3 build: continuous requests on all 3 requesters -> grants cycle 0,1,2,0; rr_ptr never reaches 3.
